serial_cfg_rx: RTL and testbench
================================

# serial_cfg_rx

Serial control-bus receiver that sits directly upstream of the chip's configuration register file. It decodes 40-bit frames on the SEN/SCLK/SDI pins (the same pins the host and bench drive with `send_config_word`) into single-cycle register-write strobes. It also serves read-back frames on a serial data-out pin. All serial inputs are asynchronous to `master_clk`; the block oversamples them.

## Interface
Parameters:
- `FRAME_BITS`, 40: header (8) + data (32) bit count per frame.
- `ERR_W`, 8: width of the saturating frame-error counter.

Ports:
- `master_clk`  in  1  system clock (sole clock).
- `reset_n`  in  1  asynchronous, active-low reset.
- `SEN`  in  1  frame enable, active high, asynchronous.
- `SCLK`  in  1  serial clock, asynchronous; data sampled on rising edge.
- `SDI`  in  1  serial data in, MSB first.
- `readback_data`  in  32  read-back word for `serial_addr`, sampled by the block.
- `SDO`  out  1  serial data out during read frames.
- `sdo_oe`  out  1  output enable for `SDO` pad.
- `serial_strobe`  out  1  one-cycle write strobe.
- `serial_addr`  out  7  register address, held until the next frame's header completes.
- `serial_data`  out  32  write data, valid while `serial_strobe` is high; held afterwards.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `frame_err_count`  out  ERR_W  count of malformed frames, saturating.

## Operation
- **Synchronizers.** `SEN`, `SCLK`, `SDI` each pass through a 2-flop synchronizer plus a third flop for edge detection. An `SCLK` rising edge is detected when s3=0 & s2=1; a falling edge when s3=1 & s2=0. `SDI` is taken from its s2 stage on the detected `SCLK` rising edge.
- **Frame format**, MSB first:
  - bit 39: R/W, 1 = read.
  - bits 38:32: address.
  - bits 31:0: data.
- **Bit counter.** 6 bits, cleared in IDLE, incremented per detected `SCLK` rise while `SEN`(sync)=1.
- **FSM states:** IDLE, HEADER, WDATA, RDATA, OVERRUN.
  - IDLE → HEADER on synced `SEN` rising edge.
  - HEADER → WDATA (R/W=0) or RDATA (R/W=1) after the 8th bit. On entry, `serial_addr` is loaded from header bits 6:0.
  - RDATA entry:
    - The cycle after entry, `readback_data` is latched into a 32-bit shift register.
    - `SDO` = bit 31 and `sdo_oe` = 1.
    - On each detected `SCLK` falling edge, shift left; the next bit appears on `SDO`.
  - WDATA/RDATA → OVERRUN on a 41st `SCLK` rise.
  - Any state → IDLE on synced `SEN` falling edge.
- **Frame end (synced `SEN` fall):**
  - Write frame with exactly 40 bits: `serial_data` is loaded and `serial_strobe` pulses for 1 cycle.
  - Read frame with exactly 40 bits: no strobe.
  - Count 0: no action, no error.
  - Count 1–39 or OVERRUN: frame discarded, no strobe, `frame_err_count` increments and saturates at all-ones.
- `sdo_oe` is deasserted in every state except RDATA.
- **Reset values:** all outputs 0, FSM IDLE, synchronizers 0. An asynchronous reset mid-frame aborts the frame with no strobe and no error count. A frame already in progress when reset releases (`SEN` already high) is ignored until `SEN` falls and rises again.

## Timing
- **Input constraints:** `SCLK` high and low ≥ 4 `master_clk` periods each. `SDI` stable ≥ 3 periods around the `SCLK` rise. `SEN` setup/hold to first/last `SCLK` ≥ 4 periods.
- **Strobe latency:** `SEN` pin low → `serial_strobe` high at the 3rd `master_clk` rising edge (2 sync + 1 register). The strobe is exactly 1 cycle wide.
- **Address latency:** 8th `SCLK` pin rise → `serial_addr` updated at the 3rd `master_clk` edge.
- **Read-back latch:** `readback_data` must be valid by the 4th edge after the 8th `SCLK` rise. `SDO` bit 31 is valid from the 5th edge.
- **SDO shift:** each subsequent `SDO` bit is valid 3 edges after the `SCLK` pin fall. The host samples it on the next `SCLK` rise.
- **Back-to-back frames:** `SEN` low ≥ 4 periods between frames. A `SEN` rise on the cycle after the strobe is accepted.

## Test plan
- **Write:** frame write, addr 7'h05, data 32'h01234567 → one `serial_strobe` pulse 3 clocks after `SEN` fall, `serial_addr`=5, `serial_data`=32'h01234567, `frame_err_count`=0.
- **Back-to-back writes:** ten writes (addresses 0–9, data 0) → exactly ten strobes with matching addresses, `busy` low between frames.
- **Read:** frame with R/W=1, addr 7'h10, `readback_data`=32'hDEADBEEF → bits sampled on the 32 `SCLK` rises reconstruct 32'hDEADBEEF, `sdo_oe` high only during RDATA, no strobe.
- **Malformed frames:** 39-bit frame, then 41-bit frame, then 0-bit frame → no strobes, `frame_err_count`=2. After 300 short frames, the count reads 255.
- **Reset mid-frame:** `reset_n` low after 20 bits of a write → all outputs 0 immediately. The next full 40-bit write strobes normally with the correct data.
- **Near-limit clocking:** `SCLK` at the minimum 4-cycle high/low with random `SDI` over 100 frames → every write strobes with the data matching the bench model.

Source files
------------

// File: rtl/serial_cfg_rx.sv
// rtl/serial_cfg_rx.sv - serial control-bus receiver: SEN/SCLK/SDI frames to register-write strobes
// Oversamples the asynchronous serial pins on master_clk and serves read-back on SDO.
module serial_cfg_rx #(
  parameter int FRAME_BITS = 40,
  parameter int ERR_W      = 8
) (
  input  logic              master_clk,
  input  logic              reset_n,
  input  logic              SEN,
  input  logic              SCLK,
  input  logic              SDI,
  input  logic [31:0]       readback_data,
  output logic              SDO,
  output logic              sdo_oe,
  output logic              serial_strobe,
  output logic [6:0]        serial_addr,
  output logic [31:0]       serial_data,
  output logic              busy,
  output logic [ERR_W-1:0]  frame_err_count
);

  localparam logic [5:0] LP_HDR_LAST  = 6'd7;
  localparam logic [5:0] LP_FRAME     = 6'(FRAME_BITS);
  localparam logic [5:0] LP_RD_SHIFT  = 6'd9;
  localparam logic [5:0] LP_CNT_MAX   = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_WDATA,
    ST_RDATA,
    ST_OVERRUN
  } state_t;

  logic             r_sen_s1, r_sen_s2, r_sen_s3;
  logic             r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic             r_sdi_s1, r_sdi_s2;
  logic [1:0]       r_settle;
  logic             r_armed;

  state_t           r_state;
  logic [5:0]       r_bit_cnt;
  logic [31:0]      r_shift;
  logic [31:0]      r_rd_shift;
  logic             r_rd_load;
  logic             r_sdo_load;
  logic             r_sdo;
  logic             r_sdo_oe;
  logic             r_strobe;
  logic [6:0]       r_addr;
  logic [31:0]      r_data;
  logic [ERR_W-1:0] r_err;

  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_sen_rise;
  logic             w_sen_fall;
  logic             w_bit_rise;
  logic [5:0]       w_cnt_next;
  logic [ERR_W-1:0] w_err_next;

  assign w_sclk_rise = ~r_sclk_s3 & r_sclk_s2;
  assign w_sclk_fall = r_sclk_s3 & ~r_sclk_s2;
  assign w_sen_rise  = ~r_sen_s3 & r_sen_s2;
  assign w_sen_fall  = r_sen_s3 & ~r_sen_s2;
  assign w_bit_rise  = w_sclk_rise & r_sen_s2;
  assign w_cnt_next  = (r_bit_cnt == LP_CNT_MAX) ? r_bit_cnt : r_bit_cnt + 6'd1;
  assign w_err_next  = (r_err == {ERR_W{1'b1}}) ? r_err
                                                : r_err + {{(ERR_W-1){1'b0}}, 1'b1};

  // A frame already running when reset releases must not be picked up mid-way:
  // frames are only accepted after SEN has been seen low through a settled pipeline.
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sen_s1  <= 1'b0;
      r_sen_s2  <= 1'b0;
      r_sen_s3  <= 1'b0;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_sdi_s1  <= 1'b0;
      r_sdi_s2  <= 1'b0;
      r_settle  <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      r_sen_s1  <= SEN;
      r_sen_s2  <= r_sen_s1;
      r_sen_s3  <= r_sen_s2;
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_sdi_s1  <= SDI;
      r_sdi_s2  <= r_sdi_s1;
      if (r_settle != 2'd3) begin
        r_settle <= r_settle + 2'd1;
      end
      if (r_settle == 2'd3 && !r_sen_s2) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 6'd0;
      r_shift    <= 32'd0;
      r_rd_shift <= 32'd0;
      r_rd_load  <= 1'b0;
      r_sdo_load <= 1'b0;
      r_sdo      <= 1'b0;
      r_sdo_oe   <= 1'b0;
      r_strobe   <= 1'b0;
      r_addr     <= 7'd0;
      r_data     <= 32'd0;
      r_err      <= {ERR_W{1'b0}};
    end else begin
      r_strobe <= 1'b0;
      if (r_state != ST_IDLE && w_sen_fall) begin
        r_state    <= ST_IDLE;
        r_bit_cnt  <= 6'd0;
        r_rd_load  <= 1'b0;
        r_sdo_load <= 1'b0;
        r_sdo      <= 1'b0;
        r_sdo_oe   <= 1'b0;
        if (r_state == ST_OVERRUN) begin
          r_err <= w_err_next;
        end else if (r_bit_cnt == LP_FRAME) begin
          if (r_state == ST_WDATA) begin
            r_data   <= r_shift;
            r_strobe <= 1'b1;
          end
        end else if (r_bit_cnt != 6'd0) begin
          r_err <= w_err_next;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_bit_cnt <= 6'd0;
            if (r_armed && w_sen_rise) begin
              r_state <= ST_HEADER;
            end
          end

          ST_HEADER: begin
            if (w_bit_rise) begin
              r_shift   <= {r_shift[30:0], r_sdi_s2};
              r_bit_cnt <= w_cnt_next;
              if (r_bit_cnt == LP_HDR_LAST) begin
                // r_shift[6] holds the first header bit (R/W) at this point
                r_addr <= {r_shift[5:0], r_sdi_s2};
                if (r_shift[6]) begin
                  r_state   <= ST_RDATA;
                  r_sdo_oe  <= 1'b1;
                  r_rd_load <= 1'b1;
                end else begin
                  r_state <= ST_WDATA;
                end
              end
            end
          end

          ST_WDATA: begin
            if (w_bit_rise) begin
              r_bit_cnt <= w_cnt_next;
              if (r_bit_cnt == LP_FRAME) begin
                r_state <= ST_OVERRUN;
              end else begin
                r_shift <= {r_shift[30:0], r_sdi_s2};
              end
            end
          end

          ST_RDATA: begin
            if (r_rd_load) begin
              r_rd_shift <= readback_data;
              r_rd_load  <= 1'b0;
              r_sdo_load <= 1'b1;
            end
            if (r_sdo_load) begin
              r_sdo      <= r_rd_shift[31];
              r_sdo_load <= 1'b0;
            end
            // The fall right after the header keeps bit 31 up for the host's first data rise
            if (w_sclk_fall && r_bit_cnt >= LP_RD_SHIFT) begin
              r_rd_shift <= {r_rd_shift[30:0], 1'b0};
              r_sdo      <= r_rd_shift[30];
            end
            if (w_bit_rise) begin
              r_bit_cnt <= w_cnt_next;
              if (r_bit_cnt == LP_FRAME) begin
                r_state  <= ST_OVERRUN;
                r_sdo_oe <= 1'b0;
                r_sdo    <= 1'b0;
              end
            end
          end

          ST_OVERRUN: begin
            r_state <= ST_OVERRUN;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign SDO             = r_sdo;
  assign sdo_oe          = r_sdo_oe;
  assign serial_strobe   = r_strobe;
  assign serial_addr     = r_addr;
  assign serial_data     = r_data;
  assign busy            = (r_state != ST_IDLE);
  assign frame_err_count = r_err;

endmodule

// File: tb/tb_serial_cfg_rx.sv
// tb/tb_serial_cfg_rx.sv - directed bench for serial_cfg_rx
// Drives frames on the serial pins at negedges and checks strobes, read-back and error counting.
module tb_serial_cfg_rx;

  logic        master_clk = 1'b0;
  logic        reset_n;
  logic        SEN;
  logic        SCLK;
  logic        SDI;
  logic [31:0] readback_data;
  logic        SDO;
  logic        sdo_oe;
  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        busy;
  logic [7:0]  frame_err_count;

  int          n_checks = 0;
  int          n_err    = 0;
  int          n_strobe = 0;
  int          base;
  logic [63:0] samp;
  logic [63:0] oe_samp;
  logic [63:0] w;
  logic [6:0]  m_addr;
  logic [31:0] m_data;

  always #5 master_clk = ~master_clk;

  serial_cfg_rx #(.FRAME_BITS(40), .ERR_W(8)) dut (
    .master_clk      (master_clk),
    .reset_n         (reset_n),
    .SEN             (SEN),
    .SCLK            (SCLK),
    .SDI             (SDI),
    .readback_data   (readback_data),
    .SDO             (SDO),
    .sdo_oe          (sdo_oe),
    .serial_strobe   (serial_strobe),
    .serial_addr     (serial_addr),
    .serial_data     (serial_data),
    .busy            (busy),
    .frame_err_count (frame_err_count)
  );

  always @(negedge master_clk) begin
    if (serial_strobe) n_strobe++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends word[nbits-1:0] MSB first; SDO and sdo_oe are captured just before each rise.
  task automatic send_frame(input logic [63:0] word, input int nbits, input int hl, input bit drop_sen);
    SEN  = 1'b1;
    SCLK = 1'b0;
    repeat (hl) @(negedge master_clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      SDI = word[i];
      repeat (hl) @(negedge master_clk);
      samp    = {samp[62:0], SDO};
      oe_samp = {oe_samp[62:0], sdo_oe};
      SCLK = 1'b1;
      repeat (hl) @(negedge master_clk);
      SCLK = 1'b0;
    end
    if (drop_sen) begin
      repeat (hl) @(negedge master_clk);
      SEN = 1'b0;
    end
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    SEN = 1'b0;
    SCLK = 1'b0;
    SDI = 1'b0;
    readback_data = 32'h0;
    samp = '0;
    oe_samp = '0;
    repeat (3) @(negedge master_clk);
    check("rst_strobe", serial_strobe, 0);
    check("rst_addr", serial_addr, 0);
    check("rst_data", serial_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", frame_err_count, 0);
    check("rst_sdo", SDO, 0);
    check("rst_oe", sdo_oe, 0);
    reset_n = 1'b1;
    repeat (8) @(negedge master_clk);

    // single write with exact strobe latency
    base = n_strobe;
    oe_samp = '0;
    send_frame({24'h0, 1'b0, 7'h05, 32'h01234567}, 40, 5, 1'b1);
    @(negedge master_clk); check("wr_lat1", serial_strobe, 0);
    @(negedge master_clk); check("wr_lat2", serial_strobe, 0);
    @(negedge master_clk); check("wr_strobe", serial_strobe, 1);
    check("wr_addr", serial_addr, 7'h05);
    check("wr_data", serial_data, 32'h01234567);
    @(negedge master_clk); check("wr_width", serial_strobe, 0);
    check("wr_err", frame_err_count, 0);
    check("wr_oe_off", oe_samp[39:0], 40'h0);
    repeat (4) @(negedge master_clk);
    check("wr_count", n_strobe - base, 1);

    // back-to-back writes, next SEN rise on the cycle after each strobe
    base = n_strobe;
    for (int a = 0; a < 10; a++) begin
      m_addr = 7'(a);
      send_frame({24'h0, 1'b0, m_addr, 32'h0}, 40, 5, 1'b1);
      repeat (3) @(negedge master_clk);
      check("b2b_strobe", serial_strobe, 1);
      check("b2b_addr", serial_addr, m_addr);
      @(negedge master_clk);
      check("b2b_busy", busy, 0);
    end
    repeat (6) @(negedge master_clk);
    check("b2b_count", n_strobe - base, 10);

    // read-back frame
    base = n_strobe;
    readback_data = 32'hDEADBEEF;
    samp = '0;
    oe_samp = '0;
    send_frame({24'h0, 1'b1, 7'h10, 32'h0}, 40, 4, 1'b1);
    repeat (6) @(negedge master_clk);
    check("rd_data", samp[31:0], 32'hDEADBEEF);
    check("rd_oe_window", oe_samp[39:0], 40'h00FFFFFFFF);
    check("rd_oe_after", sdo_oe, 0);
    check("rd_busy", busy, 0);
    check("rd_addr", serial_addr, 7'h10);
    check("rd_nostrobe", n_strobe - base, 0);
    check("rd_err", frame_err_count, 0);

    // near-limit clocking with random content
    base = n_strobe;
    for (int k = 0; k < 100; k++) begin
      m_addr = 7'($urandom_range(0, 127));
      m_data = $urandom;
      send_frame({24'h0, 1'b0, m_addr, m_data}, 40, 4, 1'b1);
      repeat (3) @(negedge master_clk);
      check("fast_strobe", serial_strobe, 1);
      check("fast_addr", serial_addr, m_addr);
      check("fast_data", serial_data, m_data);
      repeat (2) @(negedge master_clk);
    end
    check("fast_count", n_strobe - base, 100);

    // malformed: 39 bits, 41 bits, then empty frame
    base = n_strobe;
    send_frame(64'h00_1234_5678, 39, 4, 1'b1);
    repeat (6) @(negedge master_clk);
    send_frame(64'h00_0A12_3456_78, 41, 4, 1'b1);
    repeat (6) @(negedge master_clk);
    send_frame(64'h0, 0, 4, 1'b1);
    repeat (6) @(negedge master_clk);
    check("bad_err", frame_err_count, 2);
    check("bad_nostrobe", n_strobe - base, 0);
    for (int s = 0; s < 300; s++) begin
      send_frame(64'h1, 1, 4, 1'b1);
      repeat (5) @(negedge master_clk);
    end
    repeat (4) @(negedge master_clk);
    check("err_saturate", frame_err_count, 8'hFF);

    // reset in the middle of a write
    base = n_strobe;
    w = {24'h0, 1'b0, 7'h2A, 32'hCAFEF00D};
    send_frame(w >> 20, 20, 4, 1'b0);
    @(negedge master_clk);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_strobe", serial_strobe, 0);
    check("mid_rst_addr", serial_addr, 0);
    check("mid_rst_data", serial_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", frame_err_count, 0);
    check("mid_rst_sdo", SDO, 0);
    check("mid_rst_oe", sdo_oe, 0);
    repeat (2) @(negedge master_clk);
    reset_n = 1'b1;
    repeat (6) @(negedge master_clk);
    // SEN is still high from before reset: this whole frame must be ignored
    send_frame(w, 40, 4, 1'b1);
    repeat (6) @(negedge master_clk);
    check("stale_nostrobe", n_strobe - base, 0);
    check("stale_err", frame_err_count, 0);
    check("stale_busy", busy, 0);
    send_frame(w, 40, 4, 1'b1);
    repeat (3) @(negedge master_clk);
    check("post_strobe", serial_strobe, 1);
    check("post_addr", serial_addr, 7'h2A);
    check("post_data", serial_data, 32'hCAFEF00D);
    repeat (4) @(negedge master_clk);
    check("post_count", n_strobe - base, 1);
    check("post_err", frame_err_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
